// File: rtl/types_pkg.sv
// Shared types for the instruction fetch stage: machine word, fetch FSM
// states, the buffered fetch entry and a word-alignment helper.
package types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      DROP   = 2'd2,
      HALTED = 2'd3
   } fetch_state_t;

   // One buffered instruction together with the address it was fetched from.
   typedef struct packed {
      word_t pc;
      word_t instr;
   } fetch_entry_t;

   localparam word_t WORD_BYTES = 32'd4;

   // Force an address onto a word boundary by clearing the byte offset.
   function automatic word_t word_align(input word_t addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer between fetch and decode. Flush empties it
// in one cycle and wins over a same-cycle push or pop; push and pop in the
// same cycle both take effect with the occupancy unchanged.
module fetch_fifo
   import types_pkg::*;
#(
   parameter int DEPTH = 2
)
(
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  fetch_entry_t             i_push_data,
   input  logic                     i_pop,
   output fetch_entry_t             o_head,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   fetch_entry_t     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_empty;
   logic w_full;
   logic w_do_push;
   logic w_do_pop;

   assign w_empty   = (r_count == CNT_W'(0));
   assign w_full    = (r_count == CNT_W'(DEPTH));
   // Pops of an empty buffer are ignored; a push into a full buffer is only
   // allowed when the head leaves in the same cycle.
   assign w_do_pop  = i_pop && !w_empty;
   assign w_do_push = i_push && (!w_full || w_do_pop);

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_empty = w_empty;

   // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= PTR_W'(0);
         r_rd_ptr <= PTR_W'(0);
         r_count  <= CNT_W'(0);
      end else if (i_flush) begin
         r_wr_ptr <= PTR_W'(0);
         r_rd_ptr <= PTR_W'(0);
         r_count  <= CNT_W'(0);
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage; cleared on reset so the head reads as zero until written.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_do_push && !i_flush) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one word request at a time to instruction
// memory, buffers returned instructions with their PC for decode, and handles
// redirects (flush + refetch) and a sticky halt.
module fetch_stage
   import types_pkg::*;
#(
   parameter word_t RESET_PC   = 32'h0000_0000,
   parameter int    FIFO_DEPTH = 2
)
(
   input  logic  CLK,
   input  logic  nRST,
   output logic  imem_req,
   output word_t imem_addr,
   input  logic  imem_ready,
   input  word_t imem_rdata,
   output logic  dec_valid,
   output word_t dec_instr,
   output word_t dec_pc,
   input  logic  dec_ready,
   input  logic  redirect,
   input  word_t redirect_pc,
   input  logic  halt
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   fetch_state_t     r_state;
   fetch_state_t     w_next_state;
   word_t            r_pc;

   logic             w_req;
   logic             w_push;
   logic             w_flush;
   logic             w_load_redirect;
   logic             w_pop;
   logic             w_room;
   logic             w_fifo_empty;
   logic [CNT_W-1:0] w_fifo_count;
   fetch_entry_t     w_push_entry;
   fetch_entry_t     w_head;

   // A new request may only go out while the buffer still has a free slot,
   // which guarantees the response always has somewhere to land.
   assign w_room       = (w_fifo_count < CNT_W'(FIFO_DEPTH));
   assign w_push_entry = '{pc: r_pc, instr: imem_rdata};

   // State register.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; halt outranks everything, a response ends any wait.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (halt) begin
               w_next_state = HALTED;
            end else if (w_req) begin
               w_next_state = WAIT;
            end else begin
               w_next_state = IDLE;
            end
         end
         WAIT: begin
            if (halt) begin
               w_next_state = HALTED;
            end else if (imem_ready) begin
               w_next_state = IDLE;
            end else if (redirect) begin
               w_next_state = DROP;
            end else begin
               w_next_state = WAIT;
            end
         end
         DROP: begin
            if (halt) begin
               w_next_state = HALTED;
            end else if (imem_ready) begin
               w_next_state = IDLE;
            end else begin
               w_next_state = DROP;
            end
         end
         HALTED: begin
            w_next_state = HALTED;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Per-state control: request, push of a wanted response, flush and PC load.
   // The IDLE request is withheld during a redirect/halt cycle so that no
   // request is ever issued for a PC that is about to be discarded.
   always_comb begin
      w_req           = 1'b0;
      w_push          = 1'b0;
      w_flush         = 1'b0;
      w_load_redirect = 1'b0;
      case (r_state)
         IDLE: begin
            w_req           = w_room && !redirect && !halt;
            w_flush         = halt || redirect;
            w_load_redirect = redirect && !halt;
         end
         WAIT: begin
            w_req           = 1'b1;
            w_push          = imem_ready && !redirect && !halt;
            w_flush         = halt || redirect;
            w_load_redirect = redirect && !halt;
         end
         DROP: begin
            w_req           = 1'b0;
            w_flush         = halt || redirect;
            w_load_redirect = redirect && !halt;
         end
         HALTED: begin
            w_req           = 1'b0;
            w_flush         = 1'b1;
         end
         default: begin
            w_req           = 1'b0;
            w_flush         = 1'b1;
         end
      endcase
   end

   // Fetch PC: redirect target (word aligned) wins, else advance on each push.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_pc <= RESET_PC;
      end else if (w_load_redirect) begin
         r_pc <= word_align(redirect_pc);
      end else if (w_push) begin
         r_pc <= r_pc + WORD_BYTES;
      end else begin
         r_pc <= r_pc;
      end
   end

   // The request is suppressed while reset is held so memory sees nothing.
   assign imem_req  = w_req && nRST;
   assign imem_addr = r_pc;

   assign dec_valid = !w_fifo_empty && (r_state != HALTED);
   assign dec_instr = w_head.instr;
   assign dec_pc    = w_head.pc;
   assign w_pop     = dec_valid && dec_ready;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk       (CLK),
      .i_rst_n     (nRST),
      .i_flush     (w_flush),
      .i_push      (w_push),
      .i_push_data (w_push_entry),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_count     (w_fifo_count),
      .o_empty     (w_fifo_empty)
   );

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning instruction buffer entries (power of two, at least 2).
REQ-003 SHALL have port CLK  input  1  system clock, the only clock; all state on its rising edge.
REQ-004 SHALL have port nRST  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port imem_req  output  1  instruction memory request.
REQ-006 SHALL have port imem_addr  output  32  request word address (word_t).
REQ-007 SHALL have port imem_ready  input  1  response valid for the outstanding request.
REQ-008 SHALL have port imem_rdata  input  32  returned instruction.
REQ-009 SHALL have port dec_valid  output  1  buffer head valid toward decode.
REQ-010 SHALL have port dec_instr  output  32  head instruction, driven to control unit instr.
REQ-011 SHALL have port dec_pc  output  32  PC of head instruction.
REQ-012 SHALL have port dec_ready  input  1  decode consumes head this cycle.
REQ-013 SHALL have port redirect  input  1  branch/jump resolved; flush and refetch.
REQ-014 SHALL have port redirect_pc  input  32  new fetch PC.
REQ-015 SHALL have port halt  input  1  control unit decoded HALT.

Function
REQ-016 SHALL implement FSM IDLE, WAIT, DROP, HALTED.
REQ-017 IDLE: SHALL assert imem_req with imem_addr=pc when entries+0 < FIFO_DEPTH; SHALL go to WAIT in the same cycle.
REQ-018 WAIT: SHALL hold imem_req=1 and imem_addr stable until imem_ready; at most one request outstanding.
REQ-019 WAIT with imem_ready and no redirect: SHALL push {pc, imem_rdata}, set pc=pc+4 (32-bit wrap), and return to IDLE.
REQ-020 Handshake to decode: a pop SHALL occur when dec_valid and dec_ready; push and pop in the same cycle SHALL both take effect, count unchanged.
REQ-021 Full buffer: SHALL not issue a new request; dec_valid SHALL stay 1.
REQ-022 Empty buffer: dec_valid SHALL be 0; dec_instr/dec_pc are don't-care.
REQ-023 redirect SHALL flush all entries next cycle, load pc=redirect_pc with bits[1:0] forced to 00.
REQ-024 redirect while in WAIT without imem_ready SHALL go to DROP; DROP keeps imem_req=0 and discards the next imem_ready, then returns to IDLE.
REQ-025 redirect coincident with imem_ready SHALL discard that response and go to IDLE.
REQ-026 redirect in DROP SHALL update pc and remain in DROP.
REQ-027 halt SHALL take priority over redirect in the same cycle; SHALL enter HALTED, flush the buffer, and discard any in-flight response.
REQ-028 HALTED SHALL be sticky until nRST; imem_req=0, dec_valid=0.
REQ-029 Fetch-to-decode latency SHALL be one cycle after imem_ready when the buffer was empty.

Reset
REQ-030 On nRST low SHALL asynchronously set state IDLE, pc=RESET_PC, count=0, read/write pointers=0.
REQ-031 During reset outputs SHALL be imem_req=0, imem_addr=RESET_PC, dec_valid=0, dec_instr=0, dec_pc=0.
REQ-032 Reset mid-WAIT SHALL abandon the request; a late imem_ready after release SHALL be ignored until a new request issues.

Structure
REQ-033 word_t and fetch_state_t (the four-state enum) SHALL reside in types_pkg.
REQ-034 The buffer SHALL be a sub-module fetch_fifo (synchronous FIFO with count, flush, push, pop); FSM and PC logic stay in fetch_stage.

Verification
REQ-035 Reset, then imem_ready every 2nd cycle with dec_ready=1 -> addresses 0,4,8,12 in order; dec_pc matches; dec_instr equals the returned data.
REQ-036 dec_ready=0 with 3 responses available -> exactly 2 pushes, imem_req deasserted while full; releasing dec_ready resumes at pc=8.
REQ-037 redirect=1, redirect_pc=32'h0000_0103 while WAIT -> buffer emptied, next imem_ready dropped, next request addr 32'h0000_0100.
REQ-038 redirect and imem_ready in the same cycle -> no push; next request at redirect_pc.
REQ-039 halt and redirect in the same cycle -> HALTED, dec_valid=0, no further imem_req for 20 cycles; nRST pulse restarts at RESET_PC.
REQ-040 nRST asserted mid-WAIT, then stale imem_ready -> no push, first request after reset at RESET_PC.
